// File: rtl/pla_jbp_vector_driver.sv
// Stimulus/capture engine for the pla__jbp decode plane: drives a 36-bit vector,
// waits SETTLE_CYCLES, captures the 57-bit response and hands (x, z) downstream.
module pla_jbp_vector_driver #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [35:0] in_x,
    output logic [35:0] pla_x,
    input  logic [56:0] pla_z,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [35:0] out_x,
    output logic [56:0] out_z,
    input  logic        sig_clear,
    output logic [56:0] sig,
    output logic [15:0] vec_count,
    output logic        busy
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("SETTLE_CYCLES must be in 1..255");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] cnt;
    logic       accept;
    logic       capture;

    assign accept  = in_valid && (state == IDLE);
    assign capture = (state == SETTLE) && (cnt == 8'd0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = SETTLE;
            SETTLE:  if (cnt == 8'd0) state_next = HOLD;
            HOLD:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake decodes come from registered state only.
    always_comb begin
        in_ready = (state == IDLE);
        busy     = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= (state_next == HOLD);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pla_x <= '0;
            cnt   <= '0;
            out_x <= '0;
            out_z <= '0;
        end else begin
            if (accept) begin
                pla_x <= in_x;
                cnt   <= 8'(SETTLE_CYCLES - 1);
            end
            if (state == SETTLE && cnt != 8'd0) begin
                cnt <= cnt - 8'd1;
            end
            if (capture) begin
                out_x <= pla_x;
                out_z <= pla_z;
            end
        end
    end

    // A clear on the capture edge wins over that capture's signature/count update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig       <= '0;
            vec_count <= '0;
        end else if (sig_clear) begin
            sig       <= '0;
            vec_count <= '0;
        end else if (capture) begin
            sig <= {sig[55:0], sig[56]} ^ pla_z;
            if (vec_count != 16'hFFFF) begin
                vec_count <= vec_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pla_jbp_vector_driver.sv
// Directed bench for pla_jbp_vector_driver: one instance at SETTLE_CYCLES=2 and one
// at the minimum of 1, each driving a small stand-in PLA with a known response.
module tb_pla_jbp_vector_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [35:0] in_x = '0;
    logic        out_ready = 1'b0;
    logic        sig_clear = 1'b0;

    logic        in_valid_a = 1'b0, in_ready_a, out_valid_a, busy_a;
    logic [35:0] pla_x_a, out_x_a;
    logic [56:0] pla_z_a, out_z_a, sig_a;
    logic [15:0] vec_count_a;

    logic        in_valid_b = 1'b0, in_ready_b, out_valid_b, busy_b;
    logic [35:0] pla_x_b, out_x_b;
    logic [56:0] pla_z_b, out_z_b, sig_b;
    logic [15:0] vec_count_b;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [35:0] XA = 36'h0_0201_0000;  // bits 16, 25
    localparam logic [35:0] XB = 36'h0_3000_0000;  // bits 28, 29
    localparam logic [35:0] XC = 36'h0_3000_0001;  // bits 0, 28, 29

    always #5 clk = ~clk;

    // Stand-in plane: a shifted copy of x plus a few product/XOR terms.
    function automatic logic [56:0] pla_stub(input logic [35:0] x);
        logic [56:0] z;
        z     = {x[20:0], x};
        z[4]  = x[16] & x[25];
        z[21] = x[16] & ~x[25];
        z[48] = x[28] & x[29];
        z[53] = x[28] ^ x[29];
        return z;
    endfunction

    function automatic logic [56:0] rotl1(input logic [56:0] z);
        return {z[55:0], z[56]};
    endfunction

    assign pla_z_a = pla_stub(pla_x_a);
    assign pla_z_b = pla_stub(pla_x_b);

    pla_jbp_vector_driver #(.SETTLE_CYCLES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_x(in_x), .pla_x(pla_x_a), .pla_z(pla_z_a), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_x(out_x_a), .out_z(out_z_a), .sig_clear(sig_clear),
        .sig(sig_a), .vec_count(vec_count_a), .busy(busy_a)
    );

    pla_jbp_vector_driver #(.SETTLE_CYCLES(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_x(in_x), .pla_x(pla_x_b), .pla_z(pla_z_b), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_x(out_x_b), .out_z(out_z_b), .sig_clear(sig_clear),
        .sig(sig_b), .vec_count(vec_count_b), .busy(busy_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Waits (bounded) at negedges for out_valid on instance a.
    task automatic wait_valid_a(input string tag);
        int n;
        n = 0;
        while (!out_valid_a && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid_a) check(tag, 64'd0, 64'd1);
    endtask

    // One vector through instance b with out_ready high; returns to IDLE.
    task automatic run_b(input logic [35:0] x, input string tag);
        int n;
        in_x       = x;
        in_valid_b = 1'b1;
        @(negedge clk);
        in_valid_b = 1'b0;
        n = 0;
        while (!out_valid_b && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid_b) check(tag, 64'd0, 64'd1);
        @(negedge clk);
    endtask

    initial begin
        // 1. reset values
        #3;
        check("rst_in_ready", 64'(in_ready_a), 64'd1);
        check("rst_busy", 64'(busy_a), 64'd0);
        check("rst_out_valid", 64'(out_valid_a), 64'd0);
        check("rst_pla_x", 64'(pla_x_a), 64'd0);
        check("rst_out_z", 64'(out_z_a), 64'd0);
        check("rst_sig", 64'(sig_a), 64'd0);
        check("rst_vec_count", 64'(vec_count_a), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1. basic capture, SETTLE_CYCLES=2
        @(negedge clk);
        in_x       = XA;
        in_valid_a = 1'b1;
        out_ready  = 1'b0;
        @(negedge clk);  // accept edge A has passed
        in_valid_a = 1'b0;
        check("t1_busy", 64'(busy_a), 64'd1);
        check("t1_pla_x", 64'(pla_x_a), 64'(XA));
        check("t1_valid_a1", 64'(out_valid_a), 64'd0);
        @(negedge clk);  // A+1
        check("t1_valid_a2", 64'(out_valid_a), 64'd0);
        @(negedge clk);  // A+2
        check("t1_valid", 64'(out_valid_a), 64'd1);
        check("t1_z4", 64'(out_z_a[4]), 64'd1);
        check("t1_z21", 64'(out_z_a[21]), 64'd0);
        check("t1_out_z", 64'(out_z_a), 64'(pla_stub(XA)));
        check("t1_out_x", 64'(out_x_a), 64'(XA));
        check("t1_vec_count", 64'(vec_count_a), 64'd1);
        check("t1_sig", 64'(sig_a), 64'(pla_stub(XA)));

        // 3. backpressure with a new vector waiting
        in_x       = XC;
        in_valid_a = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t3_valid_hold", 64'(out_valid_a), 64'd1);
            check("t3_out_z_hold", 64'(out_z_a), 64'(pla_stub(XA)));
            check("t3_out_x_hold", 64'(out_x_a), 64'(XA));
            check("t3_in_ready", 64'(in_ready_a), 64'd0);
            check("t3_pla_x_hold", 64'(pla_x_a), 64'(XA));
        end
        out_ready = 1'b1;
        @(negedge clk);  // HOLD -> IDLE
        check("t3_valid_drop", 64'(out_valid_a), 64'd0);
        check("t3_in_ready_back", 64'(in_ready_a), 64'd1);
        check("t3_pla_x_kept", 64'(pla_x_a), 64'(XA));
        @(negedge clk);  // second vector accepted
        in_valid_a = 1'b0;
        check("t3_accept2", 64'(pla_x_a), 64'(XC));
        check("t3_in_ready_low", 64'(in_ready_a), 64'd0);

        // 4. signature rotate-and-XOR
        wait_valid_a("t4_timeout");
        check("t4_out_z", 64'(out_z_a), 64'(pla_stub(XC)));
        check("t4_sig", 64'(sig_a), 64'(rotl1(pla_stub(XA)) ^ pla_stub(XC)));
        check("t4_vec_count", 64'(vec_count_a), 64'd2);
        @(negedge clk);
        check("t4_idle", 64'(busy_a), 64'd0);

        // 2. minimum settle, out_ready tied high
        in_x       = XB;
        in_valid_b = 1'b1;
        @(negedge clk);  // A
        in_valid_b = 1'b0;
        check("t2_valid_a0", 64'(out_valid_b), 64'd0);
        check("t2_in_ready_a0", 64'(in_ready_b), 64'd0);
        @(negedge clk);  // A+1
        check("t2_valid", 64'(out_valid_b), 64'd1);
        check("t2_z48", 64'(out_z_b[48]), 64'd1);
        check("t2_z53", 64'(out_z_b[53]), 64'd0);
        check("t2_in_ready_a1", 64'(in_ready_b), 64'd0);
        @(negedge clk);  // A+2
        check("t2_in_ready_a2", 64'(in_ready_b), 64'd1);
        check("t2_valid_drop", 64'(out_valid_b), 64'd0);
        check("t2_pla_x_kept", 64'(pla_x_b), 64'(XB));

        // 4. count saturation from a preloaded value
        force dut_b.vec_count = 16'hFFFE;
        #1;
        release dut_b.vec_count;
        check("t4_preload", 64'(vec_count_b), 64'hFFFE);
        run_b(XA, "t4_sat1_timeout");
        check("t4_sat1", 64'(vec_count_b), 64'hFFFF);
        run_b(XC, "t4_sat2_timeout");
        check("t4_sat2", 64'(vec_count_b), 64'hFFFF);

        // 5. sig_clear on the capture edge
        in_x       = XB;
        in_valid_a = 1'b1;
        @(negedge clk);  // A
        in_valid_a = 1'b0;
        @(negedge clk);  // A+1
        sig_clear = 1'b1;
        @(negedge clk);  // A+2 capture
        sig_clear = 1'b0;
        check("t5_sig", 64'(sig_a), 64'd0);
        check("t5_vec_count", 64'(vec_count_a), 64'd0);
        check("t5_valid", 64'(out_valid_a), 64'd1);
        check("t5_out_z", 64'(out_z_a), 64'(pla_stub(XB)));
        check("t5_out_x", 64'(out_x_a), 64'(XB));
        check("t5_other_cleared", 64'(vec_count_b), 64'd0);
        @(negedge clk);

        // 6a. reset in SETTLE
        in_x       = XA;
        in_valid_a = 1'b1;
        @(negedge clk);
        in_valid_a = 1'b0;
        check("t6_in_settle", 64'(busy_a), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6s_busy", 64'(busy_a), 64'd0);
        check("t6s_in_ready", 64'(in_ready_a), 64'd1);
        check("t6s_pla_x", 64'(pla_x_a), 64'd0);
        check("t6s_out_x", 64'(out_x_a), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t6s_no_valid", 64'(out_valid_a), 64'd0);
        end

        // 6b. reset in HOLD
        out_ready  = 1'b0;
        in_x       = XC;
        in_valid_a = 1'b1;
        @(negedge clk);
        in_valid_a = 1'b0;
        wait_valid_a("t6h_timeout");
        check("t6h_sig_before", 64'(sig_a), 64'(pla_stub(XC)));
        #2 rst_n = 1'b0;
        #1;
        check("t6h_valid", 64'(out_valid_a), 64'd0);
        check("t6h_out_z", 64'(out_z_a), 64'd0);
        check("t6h_sig", 64'(sig_a), 64'd0);
        check("t6h_vec_count", 64'(vec_count_a), 64'd0);
        check("t6h_busy", 64'(busy_a), 64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t6h_no_valid", 64'(out_valid_a), 64'd0);
            check("t6h_idle", 64'(busy_a), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
